gen3_framing_parser: RTL

//  Registered, multi-byte-per-cycle successor to the Gen3 single-byte token checker.

---
 rtl/gen3_framing_parser.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/gen3_framing_parser.sv
// Gen3 128b/130b framing parser: types every byte of a descrambled data stream
// (IDL/SDP/STP/EDB) and flags framing errors, LANES bytes per clock.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   data_in         LANES descrambled bytes, byte 0 = [7:0] = earliest
//   valid           data_in qualifier; low holds all parser state
//   sync_header     2'b01 data block, 2'b10 ordered-set block
//   block_start     byte 0 of this beat opens a block
//   byte_type_out   3-bit type per byte (registered)
//   type_valid      byte_type_out qualifier
//   tlp_len_out     last completed STP length in DW
//   tlp_len_valid   pulse: an STP token completed in this beat
//   edb             pulse: TLP ended with a C0 C0 C0 C0 final DW
//   frame_err       pulse: first framing error of the beat
//   err_code        1 bad IDLE token, 2 short STP, 3 bad SDP / OS mid-packet

module gen3_framing_parser #(
  parameter int LANES      = 4,
  parameter int MIN_TLP_DW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] data_in,
  input  logic               valid,
  input  logic [1:0]         sync_header,
  input  logic               block_start,
  output logic [3*LANES-1:0] byte_type_out,
  output logic               type_valid,
  output logic [10:0]        tlp_len_out,
  output logic               tlp_len_valid,
  output logic               edb,
  output logic               frame_err,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STP_HDR,
    S_TLP,
    S_SDP_HDR,
    S_DLLP,
    S_ERR
  } state_t;

  localparam logic [2:0] T_NONE   = 3'd0;
  localparam logic [2:0] T_IDLE   = 3'd1;
  localparam logic [2:0] T_TSTART = 3'd2;
  localparam logic [2:0] T_TDATA  = 3'd3;
  localparam logic [2:0] T_TEND   = 3'd4;
  localparam logic [2:0] T_DSTART = 3'd5;
  localparam logic [2:0] T_DDATA  = 3'd6;
  localparam logic [2:0] T_DEND   = 3'd7;

  localparam logic [10:0] MIN_LEN = 11'(MIN_TLP_DW);

  state_t      state_q;
  logic [12:0] cnt_q;
  logic [10:0] len_q;
  logic        c0_q;

  state_t      st;
  logic [12:0] cn;
  logic [10:0] ln;
  logic        c0;
  logic [7:0]  b;
  logic [2:0]  t;
  logic        pkt;
  logic        last;
  logic        fin;

  logic [3*LANES-1:0] types_n;
  logic               len_vld_n;
  logic [10:0]        len_out_n;
  logic               edb_n;
  logic               err_n;
  logic [1:0]         code_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      c0_q    <= 1'b0;
    end else if (valid) begin
      state_q <= st;
      cnt_q   <= cn;
      len_q   <= ln;
      c0_q    <= c0;
    end
  end

  // Next state: bytes walked serially, each seeing the previous byte's state.
  // cn counts bytes from the STP token's first byte, so the token itself
  // is part of the 4*len byte span.
  always_comb begin
    st        = state_q;
    cn        = cnt_q;
    ln        = len_q;
    c0        = c0_q;
    b         = '0;
    t         = T_NONE;
    last      = 1'b0;
    fin       = 1'b0;
    types_n   = '0;
    len_vld_n = 1'b0;
    len_out_n = tlp_len_out;
    edb_n     = 1'b0;
    err_n     = 1'b0;
    code_n    = 2'd0;
    pkt       = (state_q == S_STP_HDR) || (state_q == S_TLP) ||
                (state_q == S_SDP_HDR) || (state_q == S_DLLP);

    if (sync_header == 2'b10) begin
      if (pkt) begin
        st     = S_ERR;
        err_n  = 1'b1;
        code_n = 2'd3;
      end
    end else begin
      if (st == S_ERR && block_start && sync_header == 2'b01)
        st = S_IDLE;
      for (int i = 0; i < LANES; i++) begin
        b = data_in[8*i +: 8];
        t = T_NONE;
        case (st)
          S_IDLE: begin
            unique case (1'b1)
              (b == 8'h00): t = T_IDLE;
              (b[3:0] == 4'hF): begin
                t  = T_TSTART;
                ln = {7'd0, b[7:4]};
                cn = 13'd1;
                st = S_STP_HDR;
              end
              (b == 8'hF0): begin
                t  = T_DSTART;
                st = S_SDP_HDR;
              end
              default: begin
                st     = S_ERR;
                err_n  = 1'b1;
                code_n = 2'd1;
              end
            endcase
          end
          S_STP_HDR: begin
            t = T_TSTART;
            if (cn == 13'd1)
              ln[10:4] = b[6:0];
            if (cn == 13'd3) begin
              if (ln < MIN_LEN) begin
                st     = S_ERR;
                err_n  = 1'b1;
                code_n = 2'd2;
              end else begin
                len_vld_n = 1'b1;
                len_out_n = ln;
                st        = S_TLP;
                cn        = 13'd4;
              end
            end else begin
              cn = cn + 13'd1;
            end
          end
          S_TLP: begin
            last = (cn == {ln, 2'b00} - 13'd1);
            fin  = (cn[12:2] == ln - 11'd1);
            // c0 restarts on the first byte of the final DW
            if (fin)
              c0 = (cn[1:0] == 2'd0) ? (b == 8'hC0)
                                     : (c0 && b == 8'hC0);
            if (last) begin
              t     = T_TEND;
              edb_n = c0;
              st    = S_IDLE;
              cn    = '0;
            end else begin
              t  = T_TDATA;
              cn = cn + 13'd1;
            end
          end
          S_SDP_HDR: begin
            if (b == 8'hAC) begin
              t  = T_DSTART;
              st = S_DLLP;
              cn = '0;
            end else begin
              st     = S_ERR;
              err_n  = 1'b1;
              code_n = 2'd3;
            end
          end
          S_DLLP: begin
            if (cn == 13'd5) begin
              t  = T_DEND;
              st = S_IDLE;
              cn = '0;
            end else begin
              t  = T_DDATA;
              cn = cn + 13'd1;
            end
          end
          default: t = T_NONE;
        endcase
        types_n[3*i +: 3] = t;
      end
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_type_out <= '0;
      type_valid    <= 1'b0;
      tlp_len_out   <= '0;
      tlp_len_valid <= 1'b0;
      edb           <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      type_valid    <= valid;
      byte_type_out <= valid ? types_n : '0;
      tlp_len_valid <= valid & len_vld_n;
      edb           <= valid & edb_n;
      frame_err     <= valid & err_n;
      err_code      <= valid ? code_n : 2'd0;
      if (valid)
        tlp_len_out <= len_out_n;
    end
  end

endmodule
